// File: rtl/fp_normalize_round.sv
// fp_normalize_round: post-add stage of the binary32 adder.
// Takes the raw aligned sum, normalizes it one left shift per cycle,
// rounds to nearest-even and packs the IEEE-754 result behind valid/ready.
module fp_normalize_round #(
    parameter int ROUND_EN  = 1,
    parameter int MAX_SHIFT = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic        in_sub,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_sum,
    input  logic [2:0]  in_grs,
    input  logic        in_inf,
    input  logic        in_nan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_inexact,
    output logic        out_zero
);

    localparam int CW = $clog2(MAX_SHIFT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Captured operand bundle; exponent carries a ninth bit for carry headroom
    logic          sign_q;
    logic          sub_q;
    logic          inf_q;
    logic          nan_q;
    logic          zero_q;
    logic [8:0]    exp_q;
    logic [24:0]   sum_q;
    logic          g_q;
    logic          r_q;
    logic          s_q;
    logic [CW-1:0] shift_cnt;

    // Normalization step decode
    logic norm_special;
    logic norm_zero;
    logic norm_rshift;
    logic norm_stop;

    // Rounding and packing
    logic        round_inc;
    logic [24:0] sum_inc;
    logic [23:0] mant;
    logic [8:0]  exp_r;
    logic [7:0]  exp_enc;
    logic [31:0] result_c;
    logic        ovf_c;
    logic        inx_c;
    logic        zero_c;

    // Classify what the current NORM cycle does; the first matching rule wins
    always_comb begin
        norm_special = nan_q | inf_q;
        norm_zero    = 1'b0;
        norm_rshift  = 1'b0;
        norm_stop    = 1'b0;
        if (norm_special) begin
            norm_stop = 1'b1;
        end else if ((sum_q == 25'd0) && !g_q && !r_q && !s_q) begin
            norm_zero = 1'b1;
            norm_stop = 1'b1;
        end else if (sum_q[24]) begin
            norm_rshift = 1'b1;
            norm_stop   = 1'b1;
        end else if (sum_q[23]) begin
            norm_stop = 1'b1;
        end else if ((exp_q == 9'd1) || (shift_cnt == CW'(MAX_SHIFT))) begin
            norm_stop = 1'b1;
        end
    end

    // State register; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = NORM;
                end
            end
            NORM: begin
                if (norm_stop) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Round to nearest-even, renormalize a rounding carry and pack the result
    always_comb begin
        round_inc = (ROUND_EN != 0) && g_q && (r_q || s_q || sum_q[0]);
        sum_inc   = sum_q + {24'd0, round_inc};
        mant      = sum_inc[23:0];
        exp_r     = exp_q;
        if (sum_inc[24]) begin
            mant  = sum_inc[24:1];
            exp_r = exp_q + 9'd1;
        end
        exp_enc  = mant[23] ? exp_r[7:0] : 8'd0;
        result_c = 32'd0;
        ovf_c    = 1'b0;
        inx_c    = 1'b0;
        zero_c   = 1'b0;
        if (nan_q) begin
            result_c = 32'h7FC0_0000;
        end else if (inf_q) begin
            result_c = {sign_q, 8'hFF, 23'd0};
        end else if (zero_q) begin
            result_c = {sign_q & ~sub_q, 31'd0};
            zero_c   = 1'b1;
        end else if (exp_r >= 9'd255) begin
            result_c = {sign_q, 8'hFF, 23'd0};
            ovf_c    = 1'b1;
            inx_c    = g_q | r_q | s_q;
        end else begin
            result_c = {sign_q, exp_enc, mant[22:0]};
            inx_c    = g_q | r_q | s_q;
            zero_c   = (exp_enc == 8'd0) && (mant[22:0] == 23'd0);
        end
    end

    // Operand capture, normalization shifts and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q       <= 1'b0;
            sub_q        <= 1'b0;
            inf_q        <= 1'b0;
            nan_q        <= 1'b0;
            zero_q       <= 1'b0;
            exp_q        <= 9'd0;
            sum_q        <= 25'd0;
            g_q          <= 1'b0;
            r_q          <= 1'b0;
            s_q          <= 1'b0;
            shift_cnt    <= '0;
            out_result   <= 32'd0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
            out_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q    <= in_sign;
                        sub_q     <= in_sub;
                        inf_q     <= in_inf;
                        nan_q     <= in_nan;
                        zero_q    <= 1'b0;
                        exp_q     <= (in_exp == 8'd0) ? 9'd1 : {1'b0, in_exp};
                        sum_q     <= in_sum;
                        g_q       <= in_grs[2];
                        r_q       <= in_grs[1];
                        s_q       <= in_grs[0];
                        shift_cnt <= '0;
                    end
                end
                NORM: begin
                    if (norm_zero) begin
                        zero_q <= 1'b1;
                    end else if (norm_rshift) begin
                        sum_q <= {1'b0, sum_q[24:1]};
                        g_q   <= sum_q[0];
                        r_q   <= g_q;
                        s_q   <= s_q | r_q;
                        exp_q <= exp_q + 9'd1;
                    end else if (!norm_stop) begin
                        sum_q     <= {sum_q[23:0], g_q};
                        g_q       <= r_q;
                        r_q       <= 1'b0;
                        exp_q     <= exp_q - 9'd1;
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                ROUND: begin
                    out_result   <= result_c;
                    out_overflow <= ovf_c;
                    out_inexact  <= inx_c;
                    out_zero     <= zero_c;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round: randomized and directed checks of the normalize/round
// stage against a behavioural reference written from the arithmetic rules.
module tb_fp_normalize_round;

    localparam int ROUND_EN  = 1;
    localparam int MAX_SHIFT = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic        in_sub;
    logic [7:0]  in_exp;
    logic [24:0] in_sum;
    logic [2:0]  in_grs;
    logic        in_inf;
    logic        in_nan;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_inexact;
    logic        out_zero;

    fp_normalize_round #(
        .ROUND_EN (ROUND_EN),
        .MAX_SHIFT(MAX_SHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_sub      (in_sub),
        .in_exp      (in_exp),
        .in_sum      (in_sum),
        .in_grs      (in_grs),
        .in_inf      (in_inf),
        .in_nan      (in_nan),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_overflow(out_overflow),
        .out_inexact (out_inexact),
        .out_zero    (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic        ovf;
        logic        inx;
        logic        zero;
        int          lat;
    } expect_t;

    int      n_checks = 0;
    int      n_fail   = 0;
    int      cyc      = 0;
    int      acc_cyc  = 0;
    logic    inflight = 1'b0;
    expect_t want;

    // Reference: count leading zeros, clamp the shift by exponent floor and cap,
    // then round the 24-bit significand with plain integer arithmetic.
    function automatic expect_t model(input logic sg, input logic sb, input logic [7:0] e_in,
                                      input logic [24:0] sm, input logic [2:0] grs,
                                      input logic inf, input logic nan);
        expect_t     x;
        int          e;
        int          n;
        int          lz;
        logic        g;
        logic        r;
        logic        s;
        logic        inc;
        logic [23:0] m;
        logic [25:0] w;
        logic [24:0] val;
        logic [7:0]  enc;
        x.result = 32'd0;
        x.ovf    = 1'b0;
        x.inx    = 1'b0;
        x.zero   = 1'b0;
        x.lat    = 3;
        if (nan) begin
            x.result = 32'h7FC0_0000;
            return x;
        end
        if (inf) begin
            x.result = {sg, 8'hFF, 23'd0};
            return x;
        end
        if (sm == 25'd0 && grs == 3'd0) begin
            x.result = {sg & ~sb, 31'd0};
            x.zero   = 1'b1;
            return x;
        end
        e = (e_in == 8'd0) ? 1 : int'(e_in);
        g = grs[2];
        r = grs[1];
        s = grs[0];
        if (sm[24]) begin
            m = sm[24:1];
            s = s | r;
            r = g;
            g = sm[0];
            e = e + 1;
        end else begin
            w  = {sm[23:0], g, r};
            lz = 26;
            for (int b = 0; b < 26; b++) begin
                if (w[b]) lz = 25 - b;
            end
            n = lz;
            if (n > e - 1) n = e - 1;
            if (n > MAX_SHIFT) n = MAX_SHIFT;
            w     = w << n;
            m     = w[25:2];
            g     = w[1];
            r     = w[0];
            e     = e - n;
            x.lat = 3 + n;
        end
        inc = (ROUND_EN != 0) && g && (r || s || m[0]);
        val = {1'b0, m} + {24'd0, inc};
        if (val[24]) begin
            val = val >> 1;
            e   = e + 1;
        end
        x.inx = g | r | s;
        if (e >= 255) begin
            x.result = {sg, 8'hFF, 23'd0};
            x.ovf    = 1'b1;
        end else begin
            enc      = val[23] ? 8'(e) : 8'd0;
            x.result = {sg, enc, val[22:0]};
            x.zero   = (x.result[30:0] == 31'd0);
        end
        return x;
    endfunction

    // Single comparison point: counts every check and reports any difference
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Per-cycle compare while an operation is in flight
    task automatic compareCycle();
        int idx;
        idx = cyc - acc_cyc + 1;
        checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
        checkOutput("out_valid_timing", 32'(out_valid), 32'(idx >= want.lat));
        if (out_valid) begin
            checkOutput("out_result", out_result, want.result);
            checkOutput("out_flags", {29'd0, out_overflow, out_inexact, out_zero},
                        {29'd0, want.ovf, want.inx, want.zero});
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (inflight) compareCycle();
    endtask

    task automatic scrambleInputs();
        in_sign = 1'($urandom);
        in_sub  = 1'($urandom);
        in_exp  = 8'($urandom);
        in_sum  = 25'($urandom);
        in_grs  = 3'($urandom);
        in_inf  = 1'($urandom);
        in_nan  = 1'($urandom);
    endtask

    task automatic doReset();
        inflight = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
    endtask

    // Drive one operation, wait for its result, hold it rdy cycles, then hand off
    task automatic applyStimulus(input logic sg, input logic sb, input logic [7:0] e,
                                 input logic [24:0] sm, input logic [2:0] grs,
                                 input logic inf, input logic nan, input int rdy);
        int waited;
        want = model(sg, sb, e, sm, grs, inf, nan);
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        in_sign  = sg;
        in_sub   = sb;
        in_exp   = e;
        in_sum   = sm;
        in_grs   = grs;
        in_inf   = inf;
        in_nan   = nan;
        in_valid = 1'b1;
        inflight = 1'b1;
        acc_cyc  = cyc + 1;
        tick();
        in_valid = 1'b0;
        scrambleInputs();
        waited = 0;
        while (!out_valid && waited < 64) begin
            tick();
            waited++;
        end
        if (!out_valid) begin
            checkOutput("out_valid_timeout", 32'(out_valid), 32'd1);
            doReset();
            return;
        end
        repeat (rdy) tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        inflight  = 1'b0;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("in_ready_after_handoff", 32'(in_ready), 32'd1);
        checkOutput("out_valid_after_handoff", 32'(out_valid), 32'd0);
    endtask

    // Pin the reference model to hand-computed values, then run the DUT on it
    task automatic runDirected(input string name, input logic sg, input logic sb,
                               input logic [7:0] e, input logic [24:0] sm, input logic [2:0] grs,
                               input logic inf, input logic nan, input logic [31:0] lit_res,
                               input int lit_lat, input logic lit_ovf, input logic lit_inx,
                               input logic lit_zero, input int rdy);
        expect_t m;
        m = model(sg, sb, e, sm, grs, inf, nan);
        checkOutput({name, "_model_result"}, m.result, lit_res);
        checkOutput({name, "_model_latency"}, 32'(m.lat), 32'(lit_lat));
        checkOutput({name, "_model_flags"}, {29'd0, m.ovf, m.inx, m.zero},
                    {29'd0, lit_ovf, lit_inx, lit_zero});
        applyStimulus(sg, sb, e, sm, grs, inf, nan, rdy);
    endtask

    initial begin
        int   kind;
        int   seen;
        logic sg;
        logic sb;
        logic inf;
        logic nan;
        logic [7:0]  e;
        logic [24:0] sm;
        logic [2:0]  grs;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_sign   = 1'b0;
        in_sub    = 1'b0;
        in_exp    = 8'd0;
        in_sum    = 25'd0;
        in_grs    = 3'd0;
        in_inf    = 1'b0;
        in_nan    = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_result", out_result, 32'd0);
        checkOutput("reset_flags", {29'd0, out_overflow, out_inexact, out_zero}, 32'd0);

        runDirected("plain",      0, 0, 8'h80, 25'h0C00000, 3'b000, 0, 0, 32'h4040_0000,  3, 0, 0, 0, 0);
        runDirected("carry",      0, 0, 8'h7F, 25'h1000000, 3'b000, 0, 0, 32'h4000_0000,  3, 0, 0, 0, 1);
        runDirected("round_up",   0, 0, 8'h7F, 25'h0FFFFFF, 3'b100, 0, 0, 32'h4000_0000,  3, 0, 1, 0, 0);
        runDirected("cancel",     0, 1, 8'h8C, 25'h0000001, 3'b000, 0, 0, 32'h3A80_0000, 26, 0, 0, 0, 2);
        runDirected("denormal",   0, 0, 8'h02, 25'h0000100, 3'b000, 0, 0, 32'h0000_0200,  4, 0, 0, 0, 0);
        runDirected("overflow",   0, 0, 8'hFE, 25'h1000000, 3'b000, 0, 0, 32'h7F80_0000,  3, 1, 0, 0, 0);
        runDirected("infinity",   1, 0, 8'hFF, 25'h0800000, 3'b000, 1, 0, 32'hFF80_0000,  3, 0, 0, 0, 0);
        runDirected("nan",        0, 0, 8'hFF, 25'h0C00000, 3'b000, 0, 1, 32'h7FC0_0000,  3, 0, 0, 0, 0);
        runDirected("exact_zero", 1, 1, 8'h90, 25'h0000000, 3'b000, 0, 0, 32'h0000_0000,  3, 0, 0, 1, 5);

        // Reset in the middle of a long cancellation must discard it silently
        want     = model(0, 1, 8'h8C, 25'h0000001, 3'b000, 0, 0);
        in_sign  = 1'b0;
        in_sub   = 1'b1;
        in_exp   = 8'h8C;
        in_sum   = 25'h0000001;
        in_grs   = 3'b000;
        in_inf   = 1'b0;
        in_nan   = 1'b0;
        in_valid = 1'b1;
        inflight = 1'b1;
        acc_cyc  = cyc + 1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        doReset();
        checkOutput("midop_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midop_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midop_rst_out_result", out_result, 32'd0);
        seen = 0;
        repeat (30) begin
            tick();
            if (out_valid) seen = 1;
        end
        checkOutput("midop_no_result", 32'(seen), 32'd0);

        // Randomized operations biased toward exponent and special-case corners
        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 19);
            sg   = 1'($urandom);
            sb   = 1'($urandom);
            sm   = 25'($urandom) >> $urandom_range(0, 24);
            grs  = 3'($urandom);
            inf  = (kind == 6);
            nan  = (kind == 7);
            if (kind < 4)       e = 8'($urandom_range(0, 3));
            else if (kind < 6)  e = 8'($urandom_range(250, 255));
            else                e = 8'($urandom);
            if (kind == 8) begin
                sm  = 25'd0;
                grs = 3'd0;
            end
            if (kind == 9) sm = 25'd0;
            applyStimulus(sg, sb, e, sm, grs, inf, nan, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
